// File: rtl/mvm_uart_bridge.sv
// mvm_uart_bridge: UART byte framing to/from an MVM core (kx frame assembly, sign-extended y serialisation)
module mvm_uart_bridge #(
  parameter int BITS_PER_WORD = 8,
  parameter int R = 2,
  parameter int C = 2,
  parameter int W_X = 2,
  parameter int W_K = 2,
  parameter int W_Y_OUT = 32,
  parameter logic [BITS_PER_WORD-1:0] SYNC_BYTE = 8'hA5,
  parameter int TIMEOUT_CYCLES = 1000,
  localparam int W_BUS_KX = R*C*W_K + C*W_X,
  localparam int W_Y = W_X + W_K + $clog2(C),
  localparam int W_BUS_Y = R*W_Y,
  localparam int N_IN = (W_BUS_KX + BITS_PER_WORD - 1) / BITS_PER_WORD,
  localparam int N_OUT = R*W_Y_OUT / BITS_PER_WORD
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_byte_valid,
  input  logic [BITS_PER_WORD-1:0] s_byte_data,
  output logic                     m_kx_valid,
  input  logic                     m_kx_ready,
  output logic [W_BUS_KX-1:0]      m_kx_data,
  input  logic                     s_y_valid,
  output logic                     s_y_ready,
  input  logic [W_BUS_Y-1:0]       s_y_data,
  output logic                     m_byte_valid,
  input  logic                     m_byte_ready,
  output logic [BITS_PER_WORD-1:0] m_byte_data,
  output logic                     rx_overflow,
  output logic [7:0]               rx_timeout_cnt
);
  localparam int B = BITS_PER_WORD;
  localparam int IW = $clog2(N_IN + 1);
  localparam int OW = $clog2(N_OUT + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {HUNT, COLLECT, HOLD} rx_e;
  typedef enum logic [1:0] {IDLE, HDR, BODY} tx_e;
  rx_e rx_q;
  tx_e tx_q;
  logic [N_IN*B-1:0] ibuf_q, ibuf_d;
  logic [IW-1:0] iidx_q;
  logic [TW-1:0] idle_q;
  logic ovf_q;
  logic [7:0] tcnt_q;
  logic [R*W_Y_OUT-1:0] obuf_q, obuf_d;
  logic [OW-1:0] oidx_q;
  logic rdy_q;
  always_comb begin
    ibuf_d = ibuf_q;
    ibuf_d[iidx_q*B +: B] = s_byte_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_q <= HUNT;
      ibuf_q <= '0;
      iidx_q <= '0;
      idle_q <= '0;
      ovf_q <= 1'b0;
      tcnt_q <= '0;
    end else begin
      case (rx_q)
        HUNT: if (s_byte_valid && s_byte_data == SYNC_BYTE) begin
          rx_q <= COLLECT;
          iidx_q <= '0;
          idle_q <= '0;
        end
        COLLECT: if (s_byte_valid) begin
          ibuf_q <= ibuf_d;
          iidx_q <= iidx_q + 1'b1;
          idle_q <= '0;
          if (iidx_q == IW'(N_IN - 1)) rx_q <= HOLD;
        end else if (idle_q == TW'(TIMEOUT_CYCLES - 1)) begin
          rx_q <= HUNT;
          tcnt_q <= tcnt_q + 8'(tcnt_q != 8'hFF);
        end else idle_q <= idle_q + 1'b1;
        HOLD: begin
          if (s_byte_valid) ovf_q <= 1'b1;
          if (m_kx_ready) rx_q <= HUNT;
        end
        default: rx_q <= HUNT;
      endcase
    end
  end
  assign m_kx_valid = rx_q == HOLD;
  assign m_kx_data = ibuf_q[W_BUS_KX-1:0];
  assign rx_overflow = ovf_q;
  assign rx_timeout_cnt = tcnt_q;
  // each W_Y-bit row is widened to W_Y_OUT with its sign bit
  always_comb begin
    obuf_d = '0;
    for (int r = 0; r < R; r++)
      obuf_d[r*W_Y_OUT +: W_Y_OUT] = W_Y_OUT'($signed(s_y_data[r*W_Y +: W_Y]));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_q <= IDLE;
      obuf_q <= '0;
      oidx_q <= '0;
      rdy_q <= 1'b0;
    end else begin
      case (tx_q)
        IDLE: begin
          rdy_q <= 1'b1;
          if (s_y_valid && rdy_q) begin
            obuf_q <= obuf_d;
            tx_q <= HDR;
            rdy_q <= 1'b0;
          end
        end
        HDR: if (m_byte_ready) begin
          tx_q <= BODY;
          oidx_q <= '0;
        end
        BODY: if (m_byte_ready) begin
          oidx_q <= oidx_q + 1'b1;
          if (oidx_q == OW'(N_OUT - 1)) begin
            tx_q <= IDLE;
            rdy_q <= 1'b1;
          end
        end
        default: tx_q <= IDLE;
      endcase
    end
  end
  assign s_y_ready = rdy_q;
  assign m_byte_valid = tx_q != IDLE;
  assign m_byte_data = tx_q == HDR ? SYNC_BYTE : tx_q == BODY ? obuf_q[oidx_q*B +: B] : '0;
endmodule

// File: tb/tb_mvm_uart_bridge.sv
// tb_mvm_uart_bridge: directed checks of kx framing, timeout, overflow, y serialisation and reset abort
module tb_mvm_uart_bridge;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_byte_valid = 1'b0;
  logic [7:0] s_byte_data = '0;
  logic m_kx_valid;
  logic m_kx_ready = 1'b0;
  logic [11:0] m_kx_data;
  logic s_y_valid = 1'b0;
  logic s_y_ready;
  logic [9:0] s_y_data = '0;
  logic m_byte_valid;
  logic m_byte_ready = 1'b0;
  logic [7:0] m_byte_data;
  logic rx_overflow;
  logic [7:0] rx_timeout_cnt;
  logic [7:0] exp_b [9];
  int total = 0;
  int bad = 0;
  mvm_uart_bridge dut (
    .clk(clk), .rst(rst),
    .s_byte_valid(s_byte_valid), .s_byte_data(s_byte_data),
    .m_kx_valid(m_kx_valid), .m_kx_ready(m_kx_ready), .m_kx_data(m_kx_data),
    .s_y_valid(s_y_valid), .s_y_ready(s_y_ready), .s_y_data(s_y_data),
    .m_byte_valid(m_byte_valid), .m_byte_ready(m_byte_ready), .m_byte_data(m_byte_data),
    .rx_overflow(rx_overflow), .rx_timeout_cnt(rx_timeout_cnt)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_byte(input logic [7:0] b);
    s_byte_valid = 1'b1;
    s_byte_data = b;
    tick();
    s_byte_valid = 1'b0;
    s_byte_data = '0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++; if (m_kx_valid !== 1'b0) begin bad++; $display("FAIL rst_kx_valid got=%b exp=0", m_kx_valid); end
    total++; if (m_kx_data !== 12'h000) begin bad++; $display("FAIL rst_kx_data got=%h exp=000", m_kx_data); end
    total++; if (m_byte_valid !== 1'b0) begin bad++; $display("FAIL rst_byte_valid got=%b exp=0", m_byte_valid); end
    total++; if (m_byte_data !== 8'h00) begin bad++; $display("FAIL rst_byte_data got=%h exp=00", m_byte_data); end
    total++; if (s_y_ready !== 1'b0) begin bad++; $display("FAIL rst_y_ready got=%b exp=0", s_y_ready); end
    total++; if (rx_overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow got=%b exp=0", rx_overflow); end
    total++; if (rx_timeout_cnt !== 8'd0) begin bad++; $display("FAIL rst_timeout_cnt got=%0d exp=0", rx_timeout_cnt); end
    rst = 1'b0;
    tick();
    total++; if (s_y_ready !== 1'b1) begin bad++; $display("FAIL post_rst_y_ready got=%b exp=1", s_y_ready); end
  endtask
  task automatic test_kx_frame();
    m_kx_ready = 1'b1;
    send_byte(8'h34);
    send_byte(8'hA5);
    send_byte(8'h34);
    total++; if (m_kx_valid !== 1'b0) begin bad++; $display("FAIL kx_early_valid got=%b exp=0", m_kx_valid); end
    send_byte(8'h12);
    total++; if (m_kx_valid !== 1'b1) begin bad++; $display("FAIL kx_valid got=%b exp=1", m_kx_valid); end
    total++; if (m_kx_data !== 12'h234) begin bad++; $display("FAIL kx_data got=%h exp=234", m_kx_data); end
    tick();
    total++; if (m_kx_valid !== 1'b0) begin bad++; $display("FAIL kx_one_cycle got=%b exp=0", m_kx_valid); end
  endtask
  task automatic test_timeout();
    m_kx_ready = 1'b1;
    send_byte(8'hA5);
    send_byte(8'h34);
    repeat (999) tick();
    total++; if (rx_timeout_cnt !== 8'd0) begin bad++; $display("FAIL timeout_early got=%0d exp=0", rx_timeout_cnt); end
    tick();
    total++; if (rx_timeout_cnt !== 8'd1) begin bad++; $display("FAIL timeout_cnt got=%0d exp=1", rx_timeout_cnt); end
    send_byte(8'h12);
    total++; if (m_kx_valid !== 1'b0) begin bad++; $display("FAIL timeout_no_valid got=%b exp=0", m_kx_valid); end
    send_byte(8'hA5);
    send_byte(8'h78);
    send_byte(8'h09);
    total++; if (m_kx_valid !== 1'b1) begin bad++; $display("FAIL timeout_next_valid got=%b exp=1", m_kx_valid); end
    total++; if (m_kx_data !== 12'h978) begin bad++; $display("FAIL timeout_next_data got=%h exp=978", m_kx_data); end
    tick();
  endtask
  task automatic test_overflow();
    m_kx_ready = 1'b0;
    send_byte(8'hA5);
    send_byte(8'h78);
    send_byte(8'h09);
    total++; if (rx_overflow !== 1'b0) begin bad++; $display("FAIL ovf_before got=%b exp=0", rx_overflow); end
    send_byte(8'h55);
    total++; if (rx_overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", rx_overflow); end
    total++; if (m_kx_valid !== 1'b1) begin bad++; $display("FAIL ovf_hold_valid got=%b exp=1", m_kx_valid); end
    total++; if (m_kx_data !== 12'h978) begin bad++; $display("FAIL ovf_hold_data got=%h exp=978", m_kx_data); end
    m_kx_ready = 1'b1;
    send_byte(8'hA5);
    send_byte(8'h34);
    send_byte(8'h12);
    total++; if (m_kx_valid !== 1'b0) begin bad++; $display("FAIL ovf_handshake_drop got=%b exp=0", m_kx_valid); end
    send_byte(8'hA5);
    send_byte(8'h34);
    send_byte(8'h12);
    total++; if (m_kx_data !== 12'h234 || m_kx_valid !== 1'b1) begin bad++; $display("FAIL ovf_next_frame got=%h/%b exp=234/1", m_kx_data, m_kx_valid); end
    total++; if (rx_overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", rx_overflow); end
    tick();
  endtask
  task automatic test_rx_reset();
    m_kx_ready = 1'b1;
    send_byte(8'hA5);
    send_byte(8'h34);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    send_byte(8'h12);
    total++; if (m_kx_valid !== 1'b0) begin bad++; $display("FAIL rx_rst_abort got=%b exp=0", m_kx_valid); end
    total++; if (rx_overflow !== 1'b0) begin bad++; $display("FAIL rx_rst_ovf_clear got=%b exp=0", rx_overflow); end
  endtask
  task automatic test_tx(input logic [9:0] y, input bit toggle, input int exp_cycles);
    int n = 0;
    int cyc = 0;
    bit prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    total++; if (s_y_ready !== 1'b1) begin bad++; $display("FAIL tx_ready_idle got=%b exp=1", s_y_ready); end
    s_y_valid = 1'b1;
    s_y_data = y;
    tick();
    s_y_valid = 1'b0;
    total++; if (m_byte_valid !== 1'b1 || s_y_ready !== 1'b0) begin bad++; $display("FAIL tx_latency valid/ready got=%b/%b exp=1/0", m_byte_valid, s_y_ready); end
    while (n < 9 && cyc < 100) begin
      m_byte_ready = toggle ? (cyc % 2 == 1) : 1'b1;
      if (prev_stall) begin
        total++; if (m_byte_valid !== 1'b1 || m_byte_data !== prev_data) begin bad++; $display("FAIL tx_stall_stable got=%b/%h exp=1/%h", m_byte_valid, m_byte_data, prev_data); end
      end
      if (m_byte_valid && m_byte_ready) begin
        total++; if (m_byte_data !== exp_b[n]) begin bad++; $display("FAIL tx_byte%0d got=%h exp=%h", n, m_byte_data, exp_b[n]); end
        n++;
      end
      prev_stall = m_byte_valid && !m_byte_ready;
      prev_data = m_byte_data;
      cyc++;
      tick();
    end
    m_byte_ready = 1'b0;
    total++; if (n != 9) begin bad++; $display("FAIL tx_count got=%0d exp=9", n); end
    total++; if (cyc != exp_cycles) begin bad++; $display("FAIL tx_cycles got=%0d exp=%0d", cyc, exp_cycles); end
    total++; if (m_byte_valid !== 1'b0 || s_y_ready !== 1'b1) begin bad++; $display("FAIL tx_done valid/ready got=%b/%b exp=0/1", m_byte_valid, s_y_ready); end
  endtask
  task automatic test_tx_reset();
    s_y_valid = 1'b1;
    s_y_data = 10'h07F;
    tick();
    s_y_valid = 1'b0;
    m_byte_ready = 1'b1;
    repeat (4) tick();
    total++; if (m_byte_valid !== 1'b1 || m_byte_data !== 8'hFF) begin bad++; $display("FAIL txr_mid got=%b/%h exp=1/ff", m_byte_valid, m_byte_data); end
    rst = 1'b1;
    tick();
    total++; if (m_byte_valid !== 1'b0 || s_y_ready !== 1'b0) begin bad++; $display("FAIL txr_in_rst valid/ready got=%b/%b exp=0/0", m_byte_valid, s_y_ready); end
    rst = 1'b0;
    tick();
    total++; if (s_y_ready !== 1'b1 || m_byte_valid !== 1'b0) begin bad++; $display("FAIL txr_after ready/valid got=%b/%b exp=1/0", s_y_ready, m_byte_valid); end
    tick();
    total++; if (m_byte_valid !== 1'b0) begin bad++; $display("FAIL txr_no_more got=%b exp=0", m_byte_valid); end
    m_byte_ready = 1'b0;
    exp_b = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00};
    test_tx(10'h061, 1'b0, 9);
  endtask
  initial begin
    test_reset();
    test_kx_frame();
    test_timeout();
    test_overflow();
    test_rx_reset();
    exp_b = '{8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h03, 8'h00, 8'h00, 8'h00};
    test_tx(10'h07F, 1'b0, 9);
    test_tx(10'h07F, 1'b1, 18);
    test_tx_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
